// File: rtl/prism_sp_intr_status_unit_if.sv
// Host register port and interrupt pulse bundle for the SP interrupt status unit.
// The master side drives pulses and register strobes; the slave returns read data and irq.
interface prism_sp_intr_status_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] isr_pulses;
  logic             reg_wr;
  logic             reg_rd;
  logic [1:0]       reg_addr;
  logic [WIDTH-1:0] reg_wdata;
  logic [WIDTH-1:0] reg_rdata;
  logic             reg_rvalid;
  logic             irq;

  modport master (
    output isr_pulses, reg_wr, reg_rd, reg_addr, reg_wdata,
    input  reg_rdata, reg_rvalid, irq
  );

  modport slave (
    input  isr_pulses, reg_wr, reg_rd, reg_addr, reg_wdata,
    output reg_rdata, reg_rvalid, irq
  );
endinterface

// File: rtl/prism_sp_intr_status_unit.sv
// Sticky interrupt status register with enable mask, W1C/set access and a holdoff
// timer that spaces out re-assertions of the level irq line.
module prism_sp_intr_status_unit #(
  parameter int WIDTH         = 32,
  parameter int HOLDOFF_WIDTH = 16
) (
  input logic                         clk,
  input logic                         rst,
  prism_sp_intr_status_unit_if.slave  bus
);

  typedef enum logic {IDLE, ASSERT} state_t;

  localparam logic [1:0] ADDR_ISR     = 2'd0;
  localparam logic [1:0] ADDR_IER     = 2'd1;
  localparam logic [1:0] ADDR_ISR_SET = 2'd2;
  localparam logic [1:0] ADDR_HOLDOFF = 2'd3;

  state_t                   state, state_nxt;
  logic [WIDTH-1:0]         isr, ier, isr_nxt, rd_mux;
  logic [HOLDOFF_WIDTH-1:0] holdoff, hcnt;
  logic [WIDTH-1:0]         rdata;
  logic                     rvalid;
  logic                     wr_isr, wr_ier, wr_set, wr_hold;
  logic                     pending, irq_fall;

  assign wr_isr  = bus.reg_wr && (bus.reg_addr == ADDR_ISR);
  assign wr_ier  = bus.reg_wr && (bus.reg_addr == ADDR_IER);
  assign wr_set  = bus.reg_wr && (bus.reg_addr == ADDR_ISR_SET);
  assign wr_hold = bus.reg_wr && (bus.reg_addr == ADDR_HOLDOFF);

  // Clear is applied first so that any same-cycle set wins the collision.
  always_comb begin
    isr_nxt = isr;
    if (wr_isr) isr_nxt = isr_nxt & ~bus.reg_wdata;
    isr_nxt = isr_nxt | bus.isr_pulses;
    if (wr_set) isr_nxt = isr_nxt | bus.reg_wdata;
  end

  assign pending = |(isr & ier);

  always_comb begin
    rd_mux = '0;
    unique case (bus.reg_addr)
      ADDR_ISR:     rd_mux = isr;
      ADDR_IER:     rd_mux = ier;
      ADDR_ISR_SET: rd_mux = '0;
      ADDR_HOLDOFF: rd_mux = WIDTH'(holdoff);
      default:      rd_mux = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pending && (hcnt == '0)) state_nxt = ASSERT;
      ASSERT:  if (!pending) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign irq_fall = (state == ASSERT) && (state_nxt == IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // The holdoff value is sampled only on the falling edge of irq, so a HOLDOFF
  // write never disturbs a countdown already in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      isr     <= '0;
      ier     <= '0;
      holdoff <= '0;
      hcnt    <= '0;
      rdata   <= '0;
      rvalid  <= 1'b0;
    end else begin
      isr <= isr_nxt;
      if (wr_ier)  ier     <= bus.reg_wdata;
      if (wr_hold) holdoff <= bus.reg_wdata[HOLDOFF_WIDTH-1:0];
      if (irq_fall)          hcnt <= holdoff;
      else if (hcnt != '0)   hcnt <= hcnt - HOLDOFF_WIDTH'(1);
      rvalid <= bus.reg_rd;
      if (bus.reg_rd) rdata <= rd_mux;
    end
  end

  assign bus.reg_rdata  = rdata;
  assign bus.reg_rvalid = rvalid;
  assign bus.irq        = (state == ASSERT);

endmodule

// File: tb/tb_prism_sp_intr_status_unit.sv
// Randomized bench for the interrupt status unit: a cycle-level reference model
// feeds expectation queues that an independent monitor drains.
module tb_prism_sp_intr_status_unit;

  typedef struct {
    bit        irq;
    bit        rvalid;
    bit [31:0] rdata;
  } exp_t;

  logic clk;
  logic rst;
  int   testsRun    = 0;
  int   testsFailed = 0;

  exp_t      cycleQ[$];
  bit [31:0] rdQ[$];

  // Reference state: registers as plain values, the holdoff timer expressed as
  // the cycle of the last irq fall plus the holdoff captured at that moment.
  bit [31:0] mIsr, mIer, mHold, mRdata;
  bit        mIrq;
  longint    edgeCount;
  longint    fallCycle;
  longint    fallHold;

  prism_sp_intr_status_unit_if #(.WIDTH(32)) bus ();

  prism_sp_intr_status_unit #(.WIDTH(32), .HOLDOFF_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mIsr = 0; mIer = 0; mHold = 0; mRdata = 0; mIrq = 0;
    fallCycle = -1000000;
    fallHold  = 0;
  endtask

  task automatic modelStep(input bit r, input bit [31:0] pulses, input bit wr, input bit rd,
                           input bit [1:0] addr, input bit [31:0] wdata);
    exp_t      e;
    bit        pend;
    bit        nextIrq;
    bit [31:0] rv;
    edgeCount++;
    if (r) begin
      modelReset();
      e.irq = 0; e.rvalid = 0; e.rdata = 0;
      cycleQ.push_back(e);
      return;
    end
    pend = (mIsr & mIer) != 0;
    if (mIrq) begin
      nextIrq = pend;
      if (!pend) begin
        fallCycle = edgeCount;
        fallHold  = mHold;
      end
    end else begin
      nextIrq = pend && (edgeCount >= fallCycle + fallHold + 1);
    end
    if (rd) begin
      case (addr)
        2'd0: rv = mIsr;
        2'd1: rv = mIer;
        2'd2: rv = 0;
        default: rv = mHold;
      endcase
      rdQ.push_back(rv);
      mRdata = rv;
    end
    if (wr && addr == 2'd0) mIsr = mIsr & ~wdata;
    mIsr = mIsr | pulses;
    if (wr && addr == 2'd2) mIsr = mIsr | wdata;
    if (wr && addr == 2'd1) mIer = wdata;
    if (wr && addr == 2'd3) mHold = wdata & 32'h0000_FFFF;
    mIrq = nextIrq;
    e.irq = mIrq; e.rvalid = rd; e.rdata = mRdata;
    cycleQ.push_back(e);
  endtask

  task automatic applyStimulus(input bit r, input bit [31:0] pulses, input bit wr, input bit rd,
                               input bit [1:0] addr, input bit [31:0] wdata);
    @(negedge clk);
    rst            = r;
    bus.isr_pulses = pulses;
    bus.reg_wr     = wr;
    bus.reg_rd     = rd;
    bus.reg_addr   = addr;
    bus.reg_wdata  = wdata;
    @(posedge clk);
    #1;
    modelStep(r, pulses, wr, rd, addr, wdata);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  task automatic regWrite(input bit [1:0] addr, input bit [31:0] data);
    applyStimulus(0, 0, 1, 0, addr, data);
  endtask

  task automatic regRead(input bit [1:0] addr);
    applyStimulus(0, 0, 0, 1, addr, 0);
  endtask

  // Monitor: per-cycle expectations for irq/rvalid/rdata, plus read data popped on rvalid.
  initial begin
    exp_t      e;
    bit [31:0] want;
    forever begin
      @(negedge clk);
      if (cycleQ.size() != 0) begin
        e = cycleQ.pop_front();
        checkOutput("irq", {31'b0, bus.irq}, {31'b0, e.irq});
        checkOutput("rvalid", {31'b0, bus.reg_rvalid}, {31'b0, e.rvalid});
        checkOutput("rdata_held", bus.reg_rdata, e.rdata);
        if (bus.reg_rvalid === 1'b1) begin
          if (rdQ.size() == 0) begin
            checkOutput("unexpected_rvalid", 32'd1, 32'd0);
          end else begin
            want = rdQ.pop_front();
            checkOutput("read_data", bus.reg_rdata, want);
          end
        end
      end
    end
  end

  initial begin
    bit [31:0] p, wd;
    bit [1:0]  a;
    bit        w, rdb, rr;
    edgeCount = 0;
    modelReset();
    rst = 1'b1;
    bus.isr_pulses = 0; bus.reg_wr = 0; bus.reg_rd = 0; bus.reg_addr = 0; bus.reg_wdata = 0;

    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) regRead(2'(i));

    regWrite(1, 32'h1);
    applyStimulus(0, 32'h1, 0, 0, 0, 0);
    idle(3);
    regRead(0);
    regWrite(0, 32'h1);
    idle(3);
    regRead(0);

    regWrite(1, 32'h0);
    applyStimulus(0, 32'h8, 0, 0, 0, 0);
    idle(3);
    regRead(0);
    regWrite(1, 32'h8);
    idle(3);
    regWrite(1, 32'h0);
    idle(3);
    regWrite(0, 32'hFFFF_FFFF);

    regWrite(1, 32'h3);
    regWrite(2, 32'h3);
    idle(3);
    applyStimulus(0, 32'h2, 1, 0, 0, 32'h3);
    regRead(0);
    idle(2);
    regWrite(0, 32'hFFFF_FFFF);
    idle(2);

    regWrite(3, 32'd10);
    regWrite(1, 32'h1);
    applyStimulus(0, 32'h1, 0, 0, 0, 0);
    idle(3);
    regWrite(0, 32'h1);
    idle(2);
    applyStimulus(0, 32'h1, 0, 0, 0, 0);
    idle(14);
    regWrite(3, 32'd0);
    regWrite(0, 32'h1);
    idle(3);
    applyStimulus(0, 32'h1, 0, 0, 0, 0);
    idle(4);
    regWrite(0, 32'h1);
    idle(2);

    regWrite(2, 32'h8000_0000);
    regRead(0);
    regRead(2);
    regWrite(3, 32'h1234_5678);
    regRead(3);
    regWrite(1, 32'hA5A5_0000);
    applyStimulus(0, 0, 1, 1, 1, 32'h0000_5A5A);
    regRead(1);
    idle(2);

    regWrite(0, 32'hFFFF_FFFF);
    regWrite(3, 32'd5);
    regWrite(1, 32'h1);
    applyStimulus(0, 32'h1, 0, 0, 0, 0);
    idle(3);
    applyStimulus(1, 32'h1, 0, 0, 0, 0);
    idle(3);
    regRead(0);

    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      rr  = ($urandom_range(0, 999) < 3);
      p   = 0;
      if ($urandom_range(0, 99) < 15) p = 32'h1 << $urandom_range(0, 31);
      else if ($urandom_range(0, 99) < 3) p = $urandom;
      w   = ($urandom_range(0, 99) < 25);
      rdb = ($urandom_range(0, 99) < 30);
      a   = 2'($urandom_range(0, 3));
      case (a)
        2'd0: wd = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : $urandom;
        2'd1: wd = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom & 32'h0000_00FF);
        2'd2: wd = 32'h1 << $urandom_range(0, 31);
        default: wd = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 12));
      endcase
      applyStimulus(rr, p, w, rdb, a, wd);
    end
    idle(2);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("read_queue_drained", 32'(rdQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
